result_tx_sequencer: RTL and testbench

RESULT_TX_SEQUENCER -- requirements
Module: result_tx_sequencer

---
 rtl/result_tx_sequencer_pkg.sv | 14 +
 rtl/tx_byte_mux.sv | 25 ++
 rtl/result_tx_sequencer.sv | 105 ++++++++++
 tb/tb_result_tx_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_tx_sequencer_pkg.sv
// Shared types and constants for the result-to-UART byte sequencer.
package result_tx_sequencer_pkg;

  localparam int unsigned ByteWidth = 8;
  localparam int unsigned WordWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/tx_byte_mux.sv
// Selects one byte of the held word, most significant of the low NUM_BYTES first.
module tx_byte_mux
  import result_tx_sequencer_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic [WordWidth-1:0] word_i,
  input  logic [1:0]           idx_i,
  output logic [ByteWidth-1:0] byte_o
);

  logic [1:0] sel;

  always_comb begin
    // idx 0 maps to byte NUM_BYTES-1 of the word
    sel = 2'(NUM_BYTES - 1) - idx_i;
    unique case (sel)
      2'd0:    byte_o = word_i[7:0];
      2'd1:    byte_o = word_i[15:8];
      2'd2:    byte_o = word_i[23:16];
      default: byte_o = word_i[31:24];
    endcase
  end

endmodule

// File: rtl/result_tx_sequencer.sv
// Serialises a 32-bit ALU result into NUM_BYTES bytes for a UART transmitter,
// with optional idle gap cycles between accepted bytes.
module result_tx_sequencer
  import result_tx_sequencer_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 4,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 result_valid_i,
  input  logic [WordWidth-1:0] result_data_i,
  output logic                 result_ready_o,
  output logic                 tx_valid_o,
  output logic [ByteWidth-1:0] tx_data_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [1:0] IdxLast = 2'(NUM_BYTES - 1);
  localparam logic [7:0] GapLast = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam bit         UseGap  = (GAP_CYCLES > 0);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [7:0]           gap_q, gap_d;
  logic [WordWidth-1:0] hold_q, hold_d;
  logic [ByteWidth-1:0] mux_byte;

  tx_byte_mux #(
    .NUM_BYTES(NUM_BYTES)
  ) u_byte_mux (
    .word_i(hold_q),
    .idx_i (idx_q),
    .byte_o(mux_byte)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (result_valid_i) begin
          hold_d  = result_data_i;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (tx_ready_i) begin
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 2'd1;
            if (UseGap) begin
              gap_d   = '0;
              state_d = StGap;
            end
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d   = '0;
          state_d = StSend;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    result_ready_o = (state_q == StIdle);
    tx_valid_o     = (state_q == StSend);
    busy_o         = (state_q != StIdle);
    done_o         = (state_q == StDone);
    // Keep the byte bus quiet whenever nothing is offered
    tx_data_o      = tx_valid_o ? mux_byte : '0;
  end

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Directed bench for result_tx_sequencer across three parameterisations.
module tb_result_tx_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Instance A: NUM_BYTES=4, GAP_CYCLES=0
  logic        a_valid, a_tx_ready, a_ready, a_tx_valid, a_busy, a_done;
  logic [31:0] a_data;
  logic [7:0]  a_tx_data;
  // Instance B: NUM_BYTES=4, GAP_CYCLES=3
  logic        b_valid, b_tx_ready, b_ready, b_tx_valid, b_busy, b_done;
  logic [31:0] b_data;
  logic [7:0]  b_tx_data;
  // Instance C: NUM_BYTES=2, GAP_CYCLES=0
  logic        c_valid, c_tx_ready, c_ready, c_tx_valid, c_busy, c_done;
  logic [31:0] c_data;
  logic [7:0]  c_tx_data;

  result_tx_sequencer #(.NUM_BYTES(4), .GAP_CYCLES(0)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .result_valid_i(a_valid), .result_data_i(a_data),
    .result_ready_o(a_ready), .tx_valid_o(a_tx_valid), .tx_data_o(a_tx_data),
    .tx_ready_i(a_tx_ready), .busy_o(a_busy), .done_o(a_done)
  );

  result_tx_sequencer #(.NUM_BYTES(4), .GAP_CYCLES(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .result_valid_i(b_valid), .result_data_i(b_data),
    .result_ready_o(b_ready), .tx_valid_o(b_tx_valid), .tx_data_o(b_tx_data),
    .tx_ready_i(b_tx_ready), .busy_o(b_busy), .done_o(b_done)
  );

  result_tx_sequencer #(.NUM_BYTES(2), .GAP_CYCLES(0)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .result_valid_i(c_valid), .result_data_i(c_data),
    .result_ready_o(c_ready), .tx_valid_o(c_tx_valid), .tx_data_o(c_tx_data),
    .tx_ready_i(c_tx_ready), .busy_o(c_busy), .done_o(c_done)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    a_valid = 0; a_data = '0; a_tx_ready = 1;
    b_valid = 0; b_data = '0; b_tx_ready = 1;
    c_valid = 0; c_data = '0; c_tx_ready = 1;
    @(negedge clk);
    checks++;
    if ({a_ready, a_tx_valid, a_tx_data, a_busy, a_done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: got %b expected 1_0_00000000_0_0",
               {a_ready, a_tx_valid, a_tx_data, a_busy, a_done});
    end
    checks++;
    if ({b_ready, b_tx_valid, b_tx_data, b_busy, b_done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b: got %b expected 1_0_00000000_0_0",
               {b_ready, b_tx_valid, b_tx_data, b_busy, b_done});
    end
    checks++;
    if ({c_ready, c_tx_valid, c_tx_data, c_busy, c_done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_c: got %b expected 1_0_00000000_0_0",
               {c_ready, c_tx_valid, c_tx_data, c_busy, c_done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, a_tx_valid, a_busy, a_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release_a: got %b expected 1000", {a_ready, a_tx_valid, a_busy, a_done});
    end
  endtask

  task automatic test_basic_send;
    logic [7:0] exp [4];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    a_tx_ready = 1;
    a_valid = 1; a_data = 32'hDEADBEEF;
    @(negedge clk);
    // Input word changes after acceptance must not leak into the bytes
    a_valid = 0; a_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({a_tx_valid, a_tx_data, a_ready, a_busy} !== {1'b1, exp[i], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL basic_byte%0d: got valid=%b data=%h ready=%b busy=%b expected 1 %h 0 1",
                 i, a_tx_valid, a_tx_data, a_ready, a_busy, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if ({a_done, a_tx_valid, a_ready} !== 3'b100) begin
      errors++;
      $display("FAIL basic_done: got done/valid/ready=%b expected 100", {a_done, a_tx_valid, a_ready});
    end
    @(negedge clk);
    checks++;
    if ({a_done, a_ready, a_busy} !== 3'b010) begin
      errors++;
      $display("FAIL basic_idle: got done/ready/busy=%b expected 010", {a_done, a_ready, a_busy});
    end
  endtask

  task automatic test_backpressure;
    a_tx_ready = 1;
    a_valid = 1; a_data = 32'h12345678;
    @(negedge clk);
    a_valid = 0;
    checks++;
    if ({a_tx_valid, a_tx_data} !== {1'b1, 8'h12}) begin
      errors++;
      $display("FAIL bp_byte0: got %b %h expected 1 12", a_tx_valid, a_tx_data);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({a_tx_valid, a_tx_data} !== {1'b1, 8'h34}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %b %h expected 1 34", i, a_tx_valid, a_tx_data);
      end
      a_tx_ready = 0;
      @(negedge clk);
    end
    checks++;
    if ({a_tx_valid, a_tx_data} !== {1'b1, 8'h34}) begin
      errors++;
      $display("FAIL bp_hold_end: got %b %h expected 1 34", a_tx_valid, a_tx_data);
    end
    a_tx_ready = 1;
    @(negedge clk);
    checks++;
    if ({a_tx_valid, a_tx_data} !== {1'b1, 8'h56}) begin
      errors++;
      $display("FAIL bp_byte2: got %b %h expected 1 56", a_tx_valid, a_tx_data);
    end
    @(negedge clk);
    checks++;
    if ({a_tx_valid, a_tx_data} !== {1'b1, 8'h78}) begin
      errors++;
      $display("FAIL bp_byte3: got %b %h expected 1 78", a_tx_valid, a_tx_data);
    end
    @(negedge clk);
    checks++;
    if ({a_done, a_tx_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_done: got done/valid=%b expected 10", {a_done, a_tx_valid});
    end
    @(negedge clk);
  endtask

  task automatic test_gap;
    logic [7:0] exp [4];
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    b_tx_ready = 1;
    b_valid = 1; b_data = 32'hA1B2C3D4;
    @(negedge clk);
    b_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({b_tx_valid, b_tx_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL gap_byte%0d: got %b %h expected 1 %h", i, b_tx_valid, b_tx_data, exp[i]);
      end
      @(negedge clk);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          checks++;
          if ({b_tx_valid, b_busy, b_done} !== 3'b010) begin
            errors++;
            $display("FAIL gap_idle%0d_%0d: got valid/busy/done=%b expected 010",
                     i, g, {b_tx_valid, b_busy, b_done});
          end
          @(negedge clk);
        end
      end
    end
    checks++;
    if ({b_done, b_tx_valid} !== 2'b10) begin
      errors++;
      $display("FAIL gap_done: got done/valid=%b expected 10", {b_done, b_tx_valid});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [4];
    exp = '{8'h00, 8'h00, 8'h00, 8'h01};
    a_tx_ready = 1;
    a_valid = 1; a_data = 32'hCAFEF00D;
    @(negedge clk);
    a_valid = 0;
    checks++;
    if ({a_tx_valid, a_tx_data} !== {1'b1, 8'hCA}) begin
      errors++;
      $display("FAIL rst_byte0: got %b %h expected 1 CA", a_tx_valid, a_tx_data);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_tx_valid, a_tx_data, a_done, a_busy, a_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_async: got valid=%b data=%h done=%b busy=%b ready=%b expected 0 00 0 0 1",
               a_tx_valid, a_tx_data, a_done, a_busy, a_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({a_done, a_tx_valid} !== 2'b00) begin
        errors++;
        $display("FAIL rst_hold%0d: got done/valid=%b expected 00", i, {a_done, a_tx_valid});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    a_valid = 1; a_data = 32'h00000001;
    @(negedge clk);
    a_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({a_tx_valid, a_tx_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL rst_after_byte%0d: got %b %h expected 1 %h", i, a_tx_valid, a_tx_data, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL rst_after_done: got %b expected 1", a_done);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_reject;
    c_tx_ready = 1;
    c_valid = 1; c_data = 32'hFFFF8081;
    @(negedge clk);
    // Second word offered continuously while the first is in flight
    c_data = 32'h11223344;
    checks++;
    if ({c_tx_valid, c_tx_data, c_ready} !== {1'b1, 8'h80, 1'b0}) begin
      errors++;
      $display("FAIL nb2_byte0: got %b %h ready=%b expected 1 80 0", c_tx_valid, c_tx_data, c_ready);
    end
    @(negedge clk);
    checks++;
    if ({c_tx_valid, c_tx_data, c_ready} !== {1'b1, 8'h81, 1'b0}) begin
      errors++;
      $display("FAIL nb2_byte1: got %b %h ready=%b expected 1 81 0", c_tx_valid, c_tx_data, c_ready);
    end
    @(negedge clk);
    checks++;
    if ({c_done, c_tx_valid, c_ready} !== 3'b100) begin
      errors++;
      $display("FAIL nb2_done: got done/valid/ready=%b expected 100", {c_done, c_tx_valid, c_ready});
    end
    @(negedge clk);
    checks++;
    if ({c_ready, c_tx_valid} !== 2'b10) begin
      errors++;
      $display("FAIL nb2_ready_again: got ready/valid=%b expected 10", {c_ready, c_tx_valid});
    end
    @(negedge clk);
    c_valid = 0;
    checks++;
    if ({c_tx_valid, c_tx_data} !== {1'b1, 8'h33}) begin
      errors++;
      $display("FAIL nb2_second0: got %b %h expected 1 33", c_tx_valid, c_tx_data);
    end
    @(negedge clk);
    checks++;
    if ({c_tx_valid, c_tx_data} !== {1'b1, 8'h44}) begin
      errors++;
      $display("FAIL nb2_second1: got %b %h expected 1 44", c_tx_valid, c_tx_data);
    end
    @(negedge clk);
    checks++;
    if (c_done !== 1'b1) begin
      errors++;
      $display("FAIL nb2_second_done: got %b expected 1", c_done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_send();
    test_backpressure();
    test_gap();
    test_reset_mid();
    test_busy_reject();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
